// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan scheduler.
// New values commit at frame boundaries so a frame never mixes two values.
module seg_scan_ctrl #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic        blank_lz,
  input  logic        upd_valid,
  input  logic [15:0] upd_data,
  output logic        upd_ready,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DMAX = DW'(SCAN_DIV - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state;
  logic [DW-1:0] div, div_nx;
  logic [1:0]    digit, digit_nx;
  logic [15:0]   disp, disp_nx, pend;
  logic          pend_full;
  logic          last, wrap, xfer, capture, lz;
  logic [3:0]    nib, an_nx;
  logic [6:0]    seg_nx;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'ha: s = 7'b0001000;
      4'hb: s = 7'b0000011;
      4'hc: s = 7'b1000110;
      4'hd: s = 7'b0100001;
      4'he: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign capture = upd_valid && upd_ready;

  // Outputs are computed from next-cycle position and value.
  always_comb begin
    last     = (div == DMAX);
    wrap     = (state == SCAN) && en && last
               && (digit == 2'd3);
    xfer     = pend_full && ((state == IDLE) || wrap);
    disp_nx  = xfer ? pend : disp;
    digit_nx = '0;
    div_nx   = '0;
    if (en && state == SCAN) begin
      if (last) begin
        digit_nx = digit + 2'd1;
      end else begin
        digit_nx = digit;
        div_nx   = div + 1'b1;
      end
    end
    nib = disp_nx[{digit_nx, 2'b00} +: 4];
    lz  = 1'b0;
    case (digit_nx)
      2'd1:    lz = (disp_nx[15:4] == 12'h000);
      2'd2:    lz = (disp_nx[15:8] == 8'h00);
      2'd3:    lz = (disp_nx[15:12] == 4'h0);
      default: lz = 1'b0;
    endcase
    an_nx  = en ? ~(4'b0001 << digit_nx) : 4'b1111;
    seg_nx = (!en || (blank_lz && lz)) ? 7'h7f
             : hex7(nib);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      div        <= '0;
      digit      <= '0;
      disp       <= '0;
      pend       <= '0;
      pend_full  <= 1'b0;
      upd_ready  <= 1'b1;
      an         <= 4'b1111;
      seg        <= 7'h7f;
      frame_done <= 1'b0;
    end else begin
      state      <= en ? SCAN : IDLE;
      div        <= div_nx;
      digit      <= digit_nx;
      disp       <= disp_nx;
      an         <= an_nx;
      seg        <= seg_nx;
      frame_done <= wrap;
      if (capture) begin
        pend      <= upd_data;
        pend_full <= 1'b1;
      end else if (xfer) begin
        pend_full <= 1'b0;
      end
      // ready comes back one cycle after the transfer empties pend
      upd_ready <= capture ? 1'b0 : !pend_full;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: frame-position model plus directed
// literal checks on digit order, handshake and blanking.
module tb_seg_scan_ctrl;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        en = 1'b0;
  logic        blank_lz = 1'b0;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_data = 16'h0000;
  logic        upd_ready;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  int total = 0;
  int bad = 0;
  bit checking = 1'b0;

  seg_scan_ctrl #(.SCAN_DIV(DIV)) dut (
    .clk(clk), .rstn(rstn), .en(en), .blank_lz(blank_lz),
    .upd_valid(upd_valid), .upd_data(upd_data),
    .upd_ready(upd_ready), .an(an), .seg(seg),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001;
      14: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  // model: scanning flag, position within frame, value queue
  bit          m_on = 1'b0;
  int          m_t = 0;
  logic [15:0] m_disp = 16'h0000;
  logic [15:0] m_pend [$];
  logic [3:0]  e_an = 4'b1111;
  logic [6:0]  e_seg = 7'h7f;
  logic        e_fd = 1'b0;
  logic        e_rdy = 1'b1;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_on = 1'b0; m_t = 0; m_disp = 16'h0000;
      m_pend.delete();
      e_an = 4'b1111; e_seg = 7'h7f; e_fd = 1'b0; e_rdy = 1'b1;
    end else begin
      bit cap;
      bit rdy_n;
      int d;
      int rest;
      cap   = upd_valid && e_rdy;
      rdy_n = cap ? 1'b0 : (m_pend.size() == 0);
      e_fd  = 1'b0;
      if (!en) begin
        if (!m_on && m_pend.size() > 0) m_disp = m_pend.pop_front();
        m_on = 1'b0;
        m_t  = 0;
      end else if (!m_on) begin
        if (m_pend.size() > 0) m_disp = m_pend.pop_front();
        m_on = 1'b1;
        m_t  = 0;
      end else begin
        m_t = m_t + 1;
        if (m_t == FRAME) begin
          m_t  = 0;
          e_fd = 1'b1;
          if (m_pend.size() > 0) m_disp = m_pend.pop_front();
        end
      end
      if (cap) m_pend.push_back(upd_data);
      e_rdy = rdy_n;
      if (m_on) begin
        d     = m_t / DIV;
        rest  = int'(m_disp) >> (4 * d);
        e_an  = 4'b1111 & ~(4'b0001 << d);
        e_seg = (blank_lz && d > 0 && rest == 0) ? 7'h7f
                : glyph(rest % 16);
      end else begin
        e_an  = 4'b1111;
        e_seg = 7'h7f;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      total++;
      if ({an, seg, frame_done, upd_ready} !== {e_an, e_seg, e_fd, e_rdy}) begin
        bad++;
        $display("FAIL model t=%0t got an=%b seg=%b fd=%b rdy=%b want an=%b seg=%b fd=%b rdy=%b",
                 $time, an, seg, frame_done, upd_ready, e_an, e_seg, e_fd, e_rdy);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sync_frame();
    int n = 0;
    while (!frame_done && n < 3 * FRAME) begin
      tick();
      n++;
    end
    chk("sync_frame", frame_done, 1);
  endtask

  // starts at first cycle of digit 0, ends at first cycle of digit 3
  task automatic check_digits(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
    chk("dig0_an", an, 4'b1110); chk("dig0_seg", seg, s0); tick(DIV);
    chk("dig1_an", an, 4'b1101); chk("dig1_seg", seg, s1); tick(DIV);
    chk("dig2_an", an, 4'b1011); chk("dig2_seg", seg, s2); tick(DIV);
    chk("dig3_an", an, 4'b0111); chk("dig3_seg", seg, s3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int fdc;
    #2 rstn = 1'b0;
    #1 checking = 1'b1;
    tick(3);
    rstn = 1'b1;
    tick(20);
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, 7'h7f);
    chk("rst_rdy", upd_ready, 1);
    chk("rst_fd", frame_done, 0);

    upd_valid = 1'b1; upd_data = 16'h1234;
    tick();
    upd_valid = 1'b0;
    chk("load_rdy_low", upd_ready, 0);
    tick(3);
    en = 1'b1;
    tick();
    check_digits(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);
    sync_frame();
    fdc = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (frame_done) fdc++;
    end
    chk("fd_count", fdc, 2);

    tick(5);
    upd_valid = 1'b1; upd_data = 16'habcd;
    tick();
    upd_valid = 1'b0;
    chk("cap_rdy_low", upd_ready, 0);
    tick(2);
    chk("old_dig2", seg, 7'b0100100);
    tick(DIV);
    chk("old_dig3", seg, 7'b1111001);
    sync_frame();
    chk("new_dig0", seg, 7'b0100001);
    chk("rdy_at_fd", upd_ready, 0);
    tick();
    chk("rdy_after_fd", upd_ready, 1);
    tick(DIV - 1);
    chk("new_dig1", seg, 7'b1000110);
    tick(DIV);
    chk("new_dig2", seg, 7'b0000011);
    tick(DIV);
    chk("new_dig3", seg, 7'b0001000);

    upd_valid = 1'b1; upd_data = 16'h0005; blank_lz = 1'b1;
    tick();
    upd_valid = 1'b0;
    sync_frame();
    check_digits(7'b0010010, 7'h7f, 7'h7f, 7'h7f);
    blank_lz = 1'b0;
    sync_frame();
    check_digits(7'b0010010, 7'b1000000, 7'b1000000, 7'b1000000);

    sync_frame();
    tick(2 * DIV + 1);
    en = 1'b0;
    tick();
    chk("off_an", an, 4'b1111);
    chk("off_seg", seg, 7'h7f);
    chk("off_fd", frame_done, 0);
    tick(3);
    en = 1'b1;
    tick();
    for (int c = 0; c < DIV; c++) begin
      chk("restart_dwell", an, 4'b1110);
      tick();
    end
    chk("restart_next", an, 4'b1101);

    upd_valid = 1'b1; upd_data = 16'h0f00;
    tick();
    upd_valid = 1'b0;
    chk("pend_full", upd_ready, 0);
    rstn = 1'b0;
    #1;
    chk("arst_an", an, 4'b1111);
    chk("arst_seg", seg, 7'h7f);
    chk("arst_rdy", upd_ready, 1);
    chk("arst_fd", frame_done, 0);
    en = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick();
    en = 1'b1;
    tick();
    check_digits(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
    sync_frame();
    check_digits(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
    tick(2);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
